// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-64 control unit: states, opcodes,
// funct codes, ALU operation classes and ALU control codes.
package mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEX   = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_DADD = 6'b101100;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_DSUB = 6'b101110;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SD);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU control decode: operation class from the FSM plus funct field for R-type.
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD, F_DADD: alucontrol = ALU_ADD;
                    F_SUB, F_DSUB: alucontrol = ALU_SUB;
                    F_AND:         alucontrol = ALU_AND;
                    F_OR:          alucontrol = ALU_OR;
                    F_SLT:         alucontrol = ALU_SLT;
                    // unknown funct quietly executes as add
                    default:       alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle Moore control FSM for the 64-bit MIPS core; memory-touching
// states stretch on mem_ready.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC, wait for mem_ready
// DECODE   | compute branch target PC+imm<<2, dispatch on opcode
// MEMADR   | rs + imm -> ALUOut (load/store address)
// MEMREAD  | read memory at ALUOut into MDR, wait for mem_ready
// MEMWB    | MDR -> rt
// MEMWRITE | write rt to memory at ALUOut, wait for mem_ready
// EXECUTE  | rs op rt per funct
// ALUWB    | ALUOut -> rd
// BRANCH   | rs - rt, take ALUOut as PC when zero
// ADDIEX   | rs + imm
// ADDIWB   | ALUOut -> rt
// JUMP     | jump target -> PC
module mc_controller
    import mc_pkg::*;
#(
    parameter int                 STATE_W     = 4,
    parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               pcwrite;
    logic               branch;
    aluop_t             aluop;
    logic [2:0]         alu_dec;

    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_LD, OP_SW, OP_SD: state_next = S_MEMADR;
                    OP_RTYPE:                   state_next = S_EXECUTE;
                    OP_BEQ:                     state_next = S_BRANCH;
                    OP_ADDI, OP_DADDI:          state_next = S_ADDIEX;
                    OP_J:                       state_next = S_JUMP;
                    default:                    state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = is_store(op) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEX:   state_next = S_ADDIWB;
            default:    state_next = S_FETCH;
        endcase
    end

    // reset overrides everything so a half-finished instruction cannot strobe
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        illegal  = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_LD, OP_SW, OP_SD, OP_RTYPE,
                        OP_BEQ, OP_ADDI, OP_DADDI, OP_J: illegal = 1'b0;
                        default:                         illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMREAD:  iord = 1'b1;
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWRITE: begin
                    iord     = 1'b1;
                    memwrite = mem_ready;
                end
                S_EXECUTE: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    branch  = 1'b1;
                    pcsrc   = 2'b01;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB:   regwrite = 1'b1;
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_dec)
    );

    assign alucontrol = reset ? 3'b000 : alu_dec;
    assign pcen       = pcwrite | (branch & zero);
    assign state_dbg  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle pushes its expected
// outputs, a negedge monitor pops and compares them.
module tb_mc_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen, illegal;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen, illegal, alu_chk;
        logic [2:0] alu;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n_cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("state", 16'(state_dbg), 16'(e.st));
            chk("strobes", 16'({memwrite, irwrite, regwrite, pcen, illegal}),
                16'({e.memwrite, e.irwrite, e.regwrite, e.pcen, e.illegal}));
            chk("selects", 16'({iord, regdst, memtoreg, alusrca, alusrcb, pcsrc}),
                16'({e.iord, e.regdst, e.memtoreg, e.alusrca, e.alusrcb, e.pcsrc}));
            if (e.alu_chk) chk("alucontrol", 16'(alucontrol), 16'(e.alu));
            n_cyc++;
        end
    end

    function automatic exp_t e_base(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction
    function automatic exp_t e_reset(input logic [3:0] st);
        exp_t e;
        e = e_base(st); e.alu_chk = 1'b1; e.alu = 3'b000;
        return e;
    endfunction
    function automatic exp_t e_fetch(input logic mr);
        exp_t e;
        e = e_base(S_FETCH); e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr;
        e.alu_chk = 1'b1; e.alu = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_decode(input logic ill);
        exp_t e;
        e = e_base(S_DECODE); e.alusrcb = 2'b11; e.illegal = ill;
        e.alu_chk = 1'b1; e.alu = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_memadr();
        exp_t e;
        e = e_base(S_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        e.alu_chk = 1'b1; e.alu = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_memread();
        exp_t e;
        e = e_base(S_MEMREAD); e.iord = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_memwb();
        exp_t e;
        e = e_base(S_MEMWB); e.regwrite = 1'b1; e.memtoreg = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_memwrite(input logic mr);
        exp_t e;
        e = e_base(S_MEMWRITE); e.iord = 1'b1; e.memwrite = mr;
        return e;
    endfunction
    function automatic exp_t e_execute(input logic [2:0] alu);
        exp_t e;
        e = e_base(S_EXECUTE); e.alusrca = 1'b1; e.alu_chk = 1'b1; e.alu = alu;
        return e;
    endfunction
    function automatic exp_t e_aluwb();
        exp_t e;
        e = e_base(S_ALUWB); e.regwrite = 1'b1; e.regdst = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_branch(input logic z);
        exp_t e;
        e = e_base(S_BRANCH); e.alusrca = 1'b1; e.pcsrc = 2'b01; e.pcen = z;
        e.alu_chk = 1'b1; e.alu = 3'b110;
        return e;
    endfunction
    function automatic exp_t e_addiex();
        exp_t e;
        e = e_base(S_ADDIEX); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        e.alu_chk = 1'b1; e.alu = 3'b010;
        return e;
    endfunction
    function automatic exp_t e_addiwb();
        exp_t e;
        e = e_base(S_ADDIWB); e.regwrite = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_jump();
        exp_t e;
        e = e_base(S_JUMP); e.pcsrc = 2'b10; e.pcen = 1'b1;
        return e;
    endfunction

    task automatic cyc(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst; op = o; funct = f; zero = z; mem_ready = mr;
        sb_q.push_back(e);
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [2:0] alu);
        cyc(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_execute(alu));
        cyc(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_aluwb());
    endtask

    logic [5:0] rt_funct [8] = '{6'b100000, 6'b101100, 6'b100010, 6'b101110,
                                 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [2:0] rt_alu   [8] = '{3'b010, 3'b010, 3'b110, 3'b110,
                                 3'b000, 3'b001, 3'b111, 3'b010};

    initial begin
        @(posedge clk);
        cyc(1'b1, 6'd0, 6'd0, 1'b0, 1'b1, e_reset(S_FETCH));
        cyc(1'b1, 6'd0, 6'd0, 1'b0, 1'b1, e_reset(S_FETCH));

        for (int i = 0; i < 8; i++) run_rtype(rt_funct[i], rt_alu[i]);

        // lw with three wait cycles in MEMREAD: 8 cycles total
        cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_memadr());
        for (int i = 0; i < 3; i++) cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, e_memread());
        cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_memread());
        cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_memwb());

        cyc(1'b0, OP_LD, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_LD, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_LD, 6'd0, 1'b0, 1'b1, e_memadr());
        cyc(1'b0, OP_LD, 6'd0, 1'b0, 1'b1, e_memread());
        cyc(1'b0, OP_LD, 6'd0, 1'b0, 1'b1, e_memwb());

        // sw with a stalled fetch and a stalled write
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_memadr());
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, e_memwrite(1'b0));
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_memwrite(1'b1));

        cyc(1'b0, OP_SD, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_SD, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_SD, 6'd0, 1'b0, 1'b1, e_memadr());
        cyc(1'b0, OP_SD, 6'd0, 1'b0, 1'b1, e_memwrite(1'b1));

        for (int z = 1; z >= 0; z--) begin
            cyc(1'b0, OP_BEQ, 6'd0, 1'(z), 1'b1, e_fetch(1'b1));
            cyc(1'b0, OP_BEQ, 6'd0, 1'(z), 1'b1, e_decode(1'b0));
            cyc(1'b0, OP_BEQ, 6'd0, 1'(z), 1'b1, e_branch(1'(z)));
        end

        cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, e_addiex());
        cyc(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, e_addiwb());
        cyc(1'b0, OP_DADDI, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_DADDI, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_DADDI, 6'd0, 1'b0, 1'b1, e_addiex());
        cyc(1'b0, OP_DADDI, 6'd0, 1'b0, 1'b1, e_addiwb());

        cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, e_jump());

        // unsupported opcode: illegal pulse, straight back to FETCH
        cyc(1'b0, 6'b111000, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, 6'b111000, 6'd0, 1'b0, 1'b1, e_decode(1'b1));

        // reset during EXECUTE: no ALUWB follows
        cyc(1'b0, OP_RTYPE, 6'b100000, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_RTYPE, 6'b100000, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b1, OP_RTYPE, 6'b100000, 1'b0, 1'b1, e_reset(S_EXECUTE));

        // reset during MEMWRITE with memory ready: write strobe suppressed
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_memadr());
        cyc(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e_reset(S_MEMWRITE));

        run_rtype(6'b100101, 3'b001);
        cyc(1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));

        @(negedge clk);
        #1;
        chk("sb_drain", 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
